// File: rtl/tile_mem_port_engine_pkg.sv
// Shared types and widths for the tile memory port engine: state encoding,
// port widths and the wrapping RAM address helper.
package tile_mem_port_engine_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 16;
  localparam int COORD_W   = 8;
  localparam int MAX_WORDS = 1024;
  localparam int WORDS_W   = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD_ISSUE,
    S_RD_CAPT,
    S_DONE
  } state_t;

  // Address arithmetic is modulo the RAM depth; the carry is dropped on purpose.
  function automatic logic [ADDR_W-1:0] ram_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/tile_mem_port_engine_if.sv
// Host/array-side signal bundle of the tile memory port engine. The master
// modport is the engine; the slave modport is the host DMA plus array wrapper.
interface tile_mem_port_engine_if;
  import tile_mem_port_engine_pkg::*;

  logic                     cfg_start;
  logic                     cfg_mode;
  logic [ADDR_W-1:0]        cfg_base;
  logic [WORDS_W-1:0]       cfg_words;
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_W-1:0]        s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_W-1:0]        m_data;
  logic                     external;
  logic [COORD_W-1:0]       Tile_i;
  logic [COORD_W-1:0]       Tile_j;
  logic [COORD_W-1:0]       Block_i;
  logic [COORD_W-1:0]       Block_j;
  logic                     WEA;
  logic [ADDR_W-1:0]        ADDRA;
  logic [DATA_W-1:0]        DIA;
  logic                     WEB;
  logic [ADDR_W-1:0]        ADDRB;
  logic [DATA_W-1:0]        DIB;
  logic [DATA_W-1:0]        DOB;
  logic                     busy;
  logic                     done;

  modport master (
    input  cfg_start, cfg_mode, cfg_base, cfg_words,
    input  s_valid, s_data, m_ready, DOB,
    output s_ready, m_valid, m_data, external,
    output Tile_i, Tile_j, Block_i, Block_j,
    output WEA, ADDRA, DIA, WEB, ADDRB, DIB, busy, done
  );

  modport slave (
    output cfg_start, cfg_mode, cfg_base, cfg_words,
    output s_valid, s_data, m_ready, DOB,
    input  s_ready, m_valid, m_data, external,
    input  Tile_i, Tile_j, Block_i, Block_j,
    input  WEA, ADDRA, DIA, WEB, ADDRB, DIB, busy, done
  );

endinterface

// File: rtl/tile_mem_port_engine_scan_counter.sv
// Nested scan counter: word offset innermost, then Block_j, Block_i, Tile_j,
// Tile_i. The last flag is combinational so the FSM can finish on the same edge.
module scan_counter
  import tile_mem_port_engine_pkg::*;
#(
  parameter int ARRAY_DIM = 1,
  parameter int TILE_DIM  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  input  logic [WORDS_W-1:0] words,
  output logic [ADDR_W-1:0]  offset,
  output logic [COORD_W-1:0] block_j,
  output logic [COORD_W-1:0] block_i,
  output logic [COORD_W-1:0] tile_j,
  output logic [COORD_W-1:0] tile_i,
  output logic               last
);
  localparam logic [COORD_W-1:0] TILE_MAX  = COORD_W'(TILE_DIM - 1);
  localparam logic [COORD_W-1:0] ARRAY_MAX = COORD_W'(ARRAY_DIM - 1);

  logic off_last, bj_last, bi_last, tj_last, ti_last;

  assign off_last = ({1'b0, offset} == (words - WORDS_W'(1)));
  assign bj_last  = (block_j == TILE_MAX);
  assign bi_last  = (block_i == TILE_MAX);
  assign tj_last  = (tile_j == ARRAY_MAX);
  assign ti_last  = (tile_i == ARRAY_MAX);
  assign last     = off_last & bj_last & bi_last & tj_last & ti_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      offset  <= '0;
      block_j <= '0;
      block_i <= '0;
      tile_j  <= '0;
      tile_i  <= '0;
    end else if (advance) begin
      offset <= off_last ? '0 : offset + ADDR_W'(1);
      if (off_last) begin
        block_j <= bj_last ? '0 : block_j + COORD_W'(1);
        if (bj_last) begin
          block_i <= bi_last ? '0 : block_i + COORD_W'(1);
          if (bi_last) begin
            tile_j <= tj_last ? '0 : tile_j + COORD_W'(1);
            if (tj_last) tile_i <= ti_last ? '0 : tile_i + COORD_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/tile_mem_port_engine.sv
// Sole master of the systolic-array external memory port: streams host words
// into the tile/block/address space (LOAD) or scans it back out (READ).
module tile_mem_port_engine
  import tile_mem_port_engine_pkg::*;
#(
  parameter int ARRAY_DIM = 1,
  parameter int TILE_DIM  = 1
) (
  input logic                    clk,
  input logic                    reset,
  tile_mem_port_engine_if.master bus
);
  state_t             state;
  logic [ADDR_W-1:0]  base_q;
  logic [WORDS_W-1:0] words_q;

  logic [ADDR_W-1:0]  cnt_offset;
  logic [COORD_W-1:0] cnt_ti, cnt_tj, cnt_bi, cnt_bj;
  logic               cnt_last, cnt_clear, cnt_advance;
  logic               hs, out_free, capt, rd_phase;
  logic [ADDR_W-1:0]  cur_addr;

  logic               wea_q, busy_q, done_q, m_valid_q;
  logic [ADDR_W-1:0]  addra_q, addrb_q;
  logic [DATA_W-1:0]  dia_q, m_data_q;
  logic [COORD_W-1:0] ti_q, tj_q, bi_q, bj_q;

  scan_counter #(
    .ARRAY_DIM (ARRAY_DIM),
    .TILE_DIM  (TILE_DIM)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .words   (words_q),
    .offset  (cnt_offset),
    .block_j (cnt_bj),
    .block_i (cnt_bi),
    .tile_j  (cnt_tj),
    .tile_i  (cnt_ti),
    .last    (cnt_last)
  );

  assign hs          = (state == S_LOAD) && bus.s_valid;
  assign out_free    = !m_valid_q || bus.m_ready;
  assign capt        = (state == S_RD_CAPT) && out_free;
  assign cnt_clear   = (state == S_IDLE);
  assign cnt_advance = hs || capt;
  assign rd_phase    = (state == S_RD_ISSUE) || (state == S_RD_CAPT);
  assign cur_addr    = ram_addr(base_q, cnt_offset);

  // The wrapper's read mux is combinational on coordinates, so during a read
  // they follow the counter directly; otherwise the last registered word holds.
  assign bus.Tile_i   = rd_phase ? cnt_ti : ti_q;
  assign bus.Tile_j   = rd_phase ? cnt_tj : tj_q;
  assign bus.Block_i  = rd_phase ? cnt_bi : bi_q;
  assign bus.Block_j  = rd_phase ? cnt_bj : bj_q;
  assign bus.ADDRB    = rd_phase ? cur_addr : addrb_q;
  assign bus.WEB      = 1'b0;
  assign bus.DIB      = '0;
  assign bus.WEA      = wea_q;
  assign bus.ADDRA    = addra_q;
  assign bus.DIA      = dia_q;
  assign bus.s_ready  = (state == S_LOAD);
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.external = busy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      base_q    <= '0;
      words_q   <= '0;
      wea_q     <= 1'b0;
      addra_q   <= '0;
      dia_q     <= '0;
      addrb_q   <= '0;
      ti_q      <= '0;
      tj_q      <= '0;
      bi_q      <= '0;
      bj_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wea_q  <= 1'b0;
      done_q <= 1'b0;
      if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.cfg_start) begin
            base_q  <= bus.cfg_base;
            words_q <= bus.cfg_words;
            busy_q  <= 1'b1;
            if (bus.cfg_words == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= bus.cfg_mode ? S_RD_ISSUE : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (hs) begin
            wea_q   <= 1'b1;
            addra_q <= cur_addr;
            dia_q   <= bus.s_data;
            ti_q    <= cnt_ti;
            tj_q    <= cnt_tj;
            bi_q    <= cnt_bi;
            bj_q    <= cnt_bj;
            if (cnt_last) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_RD_ISSUE: state <= S_RD_CAPT;
        S_RD_CAPT: begin
          // Capture only when the output register is free or draining this cycle.
          if (out_free) begin
            m_data_q  <= bus.DOB;
            m_valid_q <= 1'b1;
            addrb_q   <= cur_addr;
            ti_q      <= cnt_ti;
            tj_q      <= cnt_tj;
            bi_q      <= cnt_bi;
            bj_q      <= cnt_bj;
            if (cnt_last) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_RD_ISSUE;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_mem_port_engine.sv
// Scoreboard bench for tile_mem_port_engine: expected writes/reads come from a
// nested-loop model of the scan space and are checked by a separate monitor.
module tb_tile_mem_port_engine;
  import tile_mem_port_engine_pkg::*;

  localparam int AD = 1;
  localparam int TD = 2;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] ti, tj, bi, bj;
  } word_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
    logic [7:0]  ti, tj, bi, bj;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tile_mem_port_engine_if bus();

  tile_mem_port_engine #(.ARRAY_DIM(AD), .TILE_DIM(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_seen  = 0;
  int rd_popped = 0;
  int rd_total = 0;
  int cur_mode = 0;
  int cur_total = 0;
  int last_hs_cyc = 0;
  bit abort = 1'b0;

  word_t       scan_q[$];
  logic [15:0] load_data[$];
  wr_t         wr_q[$];
  logic [15:0] rd_q[$];
  logic [9:0]  rd_addr[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] dob_fn(input logic [7:0] ti, input logic [7:0] tj,
                                         input logic [7:0] bi, input logic [7:0] bj,
                                         input logic [9:0] a);
    return {ti[0], tj[0], bi[1:0], bj[1:0], a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous-read RAM model: address seen in one cycle, data in the next.
  initial begin
    logic [15:0] nxt;
    bus.DOB = '0;
    forever begin
      @(negedge clk);
      nxt = dob_fn(bus.Tile_i, bus.Tile_j, bus.Block_i, bus.Block_j, bus.ADDRB);
      @(posedge clk);
      #1 bus.DOB = nxt;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write or a read word.
  always @(negedge clk) begin
    #1;
    if (bus.WEA === 1'b1) begin
      wr_seen++;
      if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: actual ADDRA=%0h DIA=%0h required no write", bus.ADDRA, bus.DIA);
      end else begin
        check("write", {bus.ADDRA, bus.DIA, bus.Tile_i, bus.Tile_j, bus.Block_i, bus.Block_j},
              wr_q.pop_front());
      end
    end
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: actual m_data=%0h required no word", bus.m_data);
      end else begin
        check("read_data", bus.m_data, rd_q.pop_front());
        rd_popped++;
      end
    end
    if (cur_mode == 1 && bus.m_valid === 1'b1 && bus.m_ready === 1'b0 && bus.busy === 1'b1 &&
        bus.done === 1'b0 && rd_popped + 1 < rd_total)
      check("stall_addrb", bus.ADDRB, rd_addr[rd_popped+1]);
    if (bus.done === 1'b1) begin
      if (cur_mode == 0 || cur_total == 0) begin
        check("done_writes_left", wr_q.size(), 0);
      end else begin
        check("done_mvalid", bus.m_valid, 1);
        check("done_reads_left", rd_q.size(), bus.m_ready ? 0 : 1);
      end
    end
  end

  function automatic void build_scan(input logic [9:0] base, input int words);
    word_t w;
    scan_q.delete();
    for (int ti = 0; ti < AD; ti++)
      for (int tj = 0; tj < AD; tj++)
        for (int bi = 0; bi < TD; bi++)
          for (int bj = 0; bj < TD; bj++)
            for (int off = 0; off < words; off++) begin
              w.addr = 10'((int'(base) + off) % 1024);
              w.ti = 8'(ti); w.tj = 8'(tj); w.bi = 8'(bi); w.bj = 8'(bj);
              scan_q.push_back(w);
            end
  endfunction

  task automatic start(input logic mode, input logic [9:0] base, input int words);
    @(negedge clk);
    bus.cfg_start = 1'b1;
    bus.cfg_mode  = mode;
    bus.cfg_base  = base;
    bus.cfg_words = WORDS_W'(words);
    @(posedge clk);
    #1 bus.cfg_start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int dcyc);
    lat = 0;
    dcyc = 0;
    forever begin
      @(negedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) begin
        dcyc = cyc;
        break;
      end
      if (lat > 20000) begin
        check("done_timeout", bus.done, 1);
        abort = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_load(input int pat, input int total);
    int sent = 0;
    int it = 0;
    logic v;
    wr_t e;
    while (sent < total && !abort) begin
      @(negedge clk);
      if (abort) break;
      it++;
      case (pat)
        0: v = 1'b1;
        1: v = (it % 2) == 1;
        default: v = $urandom_range(0, 1) == 1;
      endcase
      // A start request mid-scan with a different config must be ignored.
      if (pat == 1 && it == 5) begin
        bus.cfg_start = 1'b1; bus.cfg_mode = 1'b1; bus.cfg_words = 11'd7; bus.cfg_base = 10'd77;
      end else begin
        bus.cfg_start = 1'b0;
      end
      bus.s_valid = v;
      bus.s_data  = v ? load_data[sent] : 16'($urandom);
      if (v && bus.s_ready === 1'b1) begin
        e.addr = scan_q[sent].addr; e.data = load_data[sent];
        e.ti = scan_q[sent].ti; e.tj = scan_q[sent].tj;
        e.bi = scan_q[sent].bi; e.bj = scan_q[sent].bj;
        wr_q.push_back(e);
        last_hs_cyc = cyc;
        sent++;
      end
    end
    bus.cfg_start = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic prep_load(input logic [9:0] base, input int words, input bit seq);
    build_scan(base, words);
    load_data.delete();
    for (int k = 0; k < scan_q.size(); k++) load_data.push_back(seq ? 16'(k + 1) : 16'($urandom));
    cur_mode = 0;
    cur_total = scan_q.size();
    rd_total = 0;
  endtask

  task automatic run_load(input logic [9:0] base, input int words, input int pat,
                          input bit seq, input int exp_lat);
    int lat, dcyc, total;
    prep_load(base, words, seq);
    total = scan_q.size();
    start(1'b0, base, words);
    fork
      drive_load(pat, total);
      wait_done(lat, dcyc);
    join
    if (exp_lat >= 0) check("load_done_latency", lat, exp_lat);
    if (total > 0) check("done_after_last_handshake", dcyc, last_hs_cyc + 1);
    @(negedge clk); #2;
    check("load_all_written", wr_q.size(), 0);
    check("idle_after_load", bus.busy, 0);
    abort = 1'b0;
  endtask

  task automatic run_read(input logic [9:0] base, input int words, input int rpat,
                          input int exp_lat);
    int lat, dcyc;
    bit fin;
    build_scan(base, words);
    rd_q.delete();
    rd_addr.delete();
    foreach (scan_q[k]) begin
      rd_q.push_back(dob_fn(scan_q[k].ti, scan_q[k].tj, scan_q[k].bi, scan_q[k].bj, scan_q[k].addr));
      rd_addr.push_back(scan_q[k].addr);
    end
    rd_popped = 0;
    rd_total = scan_q.size();
    cur_mode = 1;
    cur_total = scan_q.size();
    fin = 1'b0;
    bus.m_ready = (rpat == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    start(1'b1, base, words);
    fork
      begin
        wait_done(lat, dcyc);
        fin = 1'b1;
      end
      begin
        int it = 0;
        while (!fin && !abort) begin
          @(negedge clk);
          it++;
          case (rpat)
            0: bus.m_ready = 1'b1;
            1: bus.m_ready = !(it >= 6 && it < 16);
            default: bus.m_ready = ($urandom_range(0, 3) != 0);
          endcase
        end
      end
    join
    if (exp_lat >= 0) check("read_done_latency", lat, exp_lat);
    @(negedge clk);
    bus.m_ready = 1'b1;
    for (int b = 0; b < 10 && rd_q.size() > 0; b++) begin
      @(negedge clk); #2;
    end
    check("read_all_returned", rd_q.size(), 0);
    @(negedge clk); #2;
    check("mvalid_cleared", bus.m_valid, 0);
    cur_mode = 0;
    rd_total = 0;
    abort = 1'b0;
  endtask

  task automatic check_quiet(input string p);
    check({p, "_WEA"}, bus.WEA, 0);
    check({p, "_ADDRA"}, bus.ADDRA, 0);
    check({p, "_DIA"}, bus.DIA, 0);
    check({p, "_ADDRB"}, bus.ADDRB, 0);
    check({p, "_coords"}, {bus.Tile_i, bus.Tile_j, bus.Block_i, bus.Block_j}, 0);
    check({p, "_external"}, bus.external, 0);
    check({p, "_busy"}, bus.busy, 0);
    check({p, "_done"}, bus.done, 0);
    check({p, "_m_valid"}, bus.m_valid, 0);
    check({p, "_m_data"}, bus.m_data, 0);
    check({p, "_s_ready"}, bus.s_ready, 0);
    check({p, "_WEB_DIB"}, {bus.WEB, bus.DIB}, 0);
  endtask

  task automatic run_reset_abort();
    prep_load(10'd0, 3, 1'b1);
    wr_seen = 0;
    start(1'b0, 10'd0, 3);
    fork
      drive_load(0, cur_total);
      begin
        int b = 0;
        while (wr_seen < 5 && b < 50) begin
          @(negedge clk); #2;
          b++;
        end
        check("reached_5th_write", wr_seen, 5);
        reset = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk); #2;
        check_quiet("abort");
        reset = 1'b0;
        wr_q.delete();
      end
    join
    abort = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cfg_start = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_base = '0; bus.cfg_words = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check_quiet("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_load(10'd0, 3, 0, 1'b1, 13);
    run_load(10'd0, 3, 1, 1'b1, -1);
    run_read(10'd5, 2, 0, 17);
    run_read(10'd5, 2, 1, -1);
    run_load(10'd1023, 2, 0, 1'b0, 9);
    run_load(10'd0, 0, 0, 1'b0, 1);
    run_reset_abort();
    run_load(10'd0, 3, 0, 1'b1, 13);
    run_load(10'd1023, 1024, 0, 1'b0, 4097);
    for (int r = 0; r < 4; r++) begin
      run_load(10'($urandom), $urandom_range(1, 5), 2, 1'b0, -1);
      run_read(10'($urandom), $urandom_range(1, 5), 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_mem_port_engine.md
# tile_mem_port_engine

Host-side engine that drives the external memory port of the systolic-array top level (`external`, `Tile_i/j`, `Block_i/j`, `WEA/WEB`, `ADDRA/ADDRB`, `DIA/DIB`, `DOB`). In LOAD mode it turns a valid/ready word stream into a full tile/block/address write scan. In READ mode it scans the same space and returns results as a valid/ready stream. It sits between the host DMA and the array wrapper and is the only master of that port.

## Interface
- `ARRAY_DIM`, 8'h01: tiles per side; `Tile_i`/`Tile_j` span 0..ARRAY_DIM-1
- `TILE_DIM`, 8'h01: blocks per tile side; `Block_i`/`Block_j` span 0..TILE_DIM-1
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `cfg_start`  in  1  start pulse; sampled only in IDLE
- `cfg_mode`  in  1  0 = LOAD, 1 = READ; latched on start
- `cfg_base`  in  10  first RAM address per block; latched
- `cfg_words`  in  11  words per block, 0..1024; latched
- `s_valid` / `s_ready` / `s_data`  in/out/in  1/1/16  load stream
- `m_valid` / `m_ready` / `m_data`  out/in/out  1/1/16  readback stream
- `external`  out  1  1 whenever the engine is not IDLE
- `Tile_i`, `Tile_j`, `Block_i`, `Block_j`  out  8 each  current coordinates
- `WEA`, `ADDRA`, `DIA`  out  1/10/16  write port
- `WEB`, `ADDRB`, `DIB`  out  1/10/16  read port; `WEB` and `DIB` are tied to 0
- `DOB`  in  16  read data from the array wrapper
- `busy`  out  1  same as `external`
- `done`  out  1  one-cycle pulse at end of scan

## Operation
- States: IDLE, LOAD, RD_ISSUE, RD_CAPT, DONE.
- IDLE → DONE when `cfg_start` and `cfg_words` = 0. No port activity occurs.
- Otherwise IDLE goes to LOAD (`cfg_mode` = 0) or RD_ISSUE (`cfg_mode` = 1).
- Scan order, innermost first: addr offset 0..cfg_words-1, then `Block_j`, `Block_i`, `Tile_j`, `Tile_i`.
- Total words = ARRAY_DIM²·TILE_DIM²·cfg_words.
- RAM address = (`cfg_base` + offset) mod 1024; it wraps silently.
- LOAD:
  - `s_ready` = 1.
  - On each handshake, register the following from the scan counter: `WEA` = 1, `ADDRA`, `DIA` = `s_data`, and the coordinates.
  - Then advance the counter.
  - No handshake in a cycle → `WEA` = 0 next cycle, with address and coordinates held.
  - Handshake on the last word → DONE.
- READ:
  - RD_ISSUE: drive `ADDRB` and the coordinates for the current word, then go to RD_CAPT.
  - RD_CAPT: the same address and coordinates are held. At the end of this cycle, `DOB` is captured into the output register, which sets `m_valid`.
  - Coordinates stay stable for both cycles because the wrapper's read mux is combinational on them.
  - The engine leaves RD_CAPT only if the output register is empty or is being consumed (`m_valid & m_ready`) in the same cycle; otherwise it stalls in RD_CAPT.
  - After capture it advances the counter: to RD_ISSUE, or to DONE after the last word.
- DONE lasts one cycle:
  - `done` = 1 and `external` stays 1, so the final `WEA` pulse lands.
  - Next state is IDLE.
  - In READ, the last word may still sit in the output register after IDLE; `m_valid` holds until it is consumed.
- `cfg_start` while not IDLE is ignored.
- `s_ready` = 0 in every state other than LOAD.

## Timing
- Reset values: all outputs 0, `m_data` 0, state IDLE, counter 0.
- Reset mid-scan aborts: `WEA` = 0 from the next edge, no further writes, `m_valid` is cleared, no `done`.
- LOAD latency: handshake at edge t → `WEA` = 1 in cycle t+1. Throughput is 1 word/cycle.
- READ throughput is 1 word per 2 cycles with no backpressure.
- Each `m_data` value equals `DOB` sampled in the RD_CAPT cycle of that word.
- `m_data`/`m_valid` are stable while `m_valid & !m_ready`.
- `done` asserts exactly one cycle after the last load handshake, or one cycle after the last read capture.
- `cfg_words` = 1024 with `cfg_base` = 1023: addresses run 1023, 0, 1, …, 1022.

## Structure
- Shared package holds:
  - state encoding
  - `ADDR_W` = 10, `DATA_W` = 16, `COORD_W` = 8
  - `MAX_WORDS` = 1024
- One sub-module, `scan_counter`: a nested offset/Block_j/Block_i/Tile_j/Tile_i counter.
  - Inputs: `clear`, `advance`.
  - Outputs: coordinates, offset, and a combinational `last` flag.
  - Parameterised by `ARRAY_DIM`/`TILE_DIM`; `cfg_words` is a runtime input.

## Test plan
- ARRAY_DIM = 1, TILE_DIM = 2, LOAD, base 0, words 3, continuous stream 0x0001..0x000C → 12 writes. Coordinates (Bi,Bj) go (0,0)×3, (0,1)×3, (1,0)×3, (1,1)×3 with `ADDRA` 0,1,2 repeating. `done` arrives 1 cycle after the 12th handshake.
- Same config with `s_valid` toggled every other cycle → `WEA` pulses only after handshakes, address is held between them, the data sequence is unchanged.
- READ, base 5, words 2, model `DOB` = {coords, addr} → `m_data` sequence matches the model, one word per 2 cycles.
- READ with `m_ready` held low for 10 cycles mid-scan → engine stalls in RD_CAPT, no word is lost or duplicated, `ADDRB` is held.
- base 1023, words 2 → addresses 1023 then 0; `cfg_words` = 0 → `done` after 1 cycle with no `WEA`.
- Reset asserted at the 5th of 12 load writes → next cycle all outputs are 0 and state is IDLE. A fresh start afterwards completes cleanly.
